// File: rtl/reg_file_sb.sv
// GPR file with one write port, three combinational read ports, write-first bypass and a
// per-register busy scoreboard that raises a decode stall on read-after-write hazards.
// R0_ZERO=1 hardwires register 0 to zero and keeps it out of the scoreboard.
module reg_file_sb #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter bit          R0_ZERO = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [ADDR_W-1:0] rd_addr1_i,
    input  logic [ADDR_W-1:0] rd_addr2_i,
    input  logic [ADDR_W-1:0] rd_addr3_i,
    input  logic              rd_use1_i,
    input  logic              rd_use2_i,
    input  logic              rd_use3_i,
    output logic [DATA_W-1:0] rd_data1_o,
    output logic [DATA_W-1:0] rd_data2_o,
    output logic [DATA_W-1:0] rd_data3_o,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              iss_en_i,
    input  logic [ADDR_W-1:0] iss_addr_i,
    output logic              busy1_o,
    output logic              busy2_o,
    output logic              busy3_o,
    output logic              stall_o
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [Depth];
    logic [Depth-1:0]  busy_q, busy_d;

    logic [ADDR_W-1:0] rd_addr [3];
    logic              rd_use  [3];
    logic [DATA_W-1:0] rd_data [3];
    logic              rd_busy [3];

    logic wr_keep;
    logic iss_ok;

    assign rd_addr[0] = rd_addr1_i;
    assign rd_addr[1] = rd_addr2_i;
    assign rd_addr[2] = rd_addr3_i;
    assign rd_use[0]  = rd_use1_i;
    assign rd_use[1]  = rd_use2_i;
    assign rd_use[2]  = rd_use3_i;

    assign rd_data1_o = rd_data[0];
    assign rd_data2_o = rd_data[1];
    assign rd_data3_o = rd_data[2];
    assign busy1_o    = rd_busy[0];
    assign busy2_o    = rd_busy[1];
    assign busy3_o    = rd_busy[2];

    // A write to r0 in MIPS mode is dropped entirely, so it can neither land nor bypass.
    assign wr_keep = wr_en_i && !(R0_ZERO && (wr_addr_i == '0));

    // Reservation only when decode is not held; r0 in MIPS mode has no producer to track.
    assign iss_ok = iss_en_i && !stall_o && !(R0_ZERO && (iss_addr_i == '0));

    for (genvar p = 0; p < 3; p++) begin : g_rd_port
        // Write-first read with bypass; a same-cycle writeback also retires the hazard.
        always_comb begin
            rd_data[p] = regs_q[rd_addr[p]];
            if (wr_keep && (wr_addr_i == rd_addr[p])) begin
                rd_data[p] = wr_data_i;
            end else if (R0_ZERO && (rd_addr[p] == '0)) begin
                rd_data[p] = '0;
            end
            rd_busy[p] = busy_q[rd_addr[p]] && !(wr_en_i && (wr_addr_i == rd_addr[p]));
        end
    end

    // Any operand actually consumed by the decoding instruction that is still in flight.
    always_comb begin
        stall_o = (rd_use[0] && rd_busy[0]) || (rd_use[1] && rd_busy[1]) ||
                  (rd_use[2] && rd_busy[2]);
    end

    // Scoreboard next state: clear on writeback first, so a same-index issue wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_en_i) begin
            busy_d[wr_addr_i] = 1'b0;
        end
        if (iss_ok) begin
            busy_d[iss_addr_i] = 1'b1;
        end
    end

    // Register storage with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < Depth; k++) begin
                regs_q[k] <= '0;
            end
        end else if (wr_keep) begin
            regs_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Busy bits with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed vector table, hand-written R0 and reset
// sequences, then randomized traffic against an array-based reference model. Two DUTs share
// all inputs: index 0 has R0_ZERO=0, index 1 has R0_ZERO=1.
module tb_reg_file_sb;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ie;
    logic [4:0]  ia;
    logic [4:0]  ra [3];
    logic        ru [3];

    logic [31:0] rd [2][3];
    logic        bz [2][3];
    logic        st [2];

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state per mode.
    logic [31:0] mreg  [2][32];
    logic        mbusy [2][32];

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        ie;
        logic [4:0]  ia;
        logic [4:0]  a1, a2, a3;
        logic        u1, u2, u3;
        logic [31:0] e1, e2, e3;
        logic        b1, b2, b3, es;
    } vec_t;

    vec_t vecs [17];

    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .R0_ZERO(1'b0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .rd_addr1_i(ra[0]), .rd_addr2_i(ra[1]), .rd_addr3_i(ra[2]),
        .rd_use1_i(ru[0]), .rd_use2_i(ru[1]), .rd_use3_i(ru[2]),
        .rd_data1_o(rd[0][0]), .rd_data2_o(rd[0][1]), .rd_data3_o(rd[0][2]),
        .wr_en_i(we), .wr_addr_i(wa), .wr_data_i(wd),
        .iss_en_i(ie), .iss_addr_i(ia),
        .busy1_o(bz[0][0]), .busy2_o(bz[0][1]), .busy3_o(bz[0][2]),
        .stall_o(st[0])
    );

    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .R0_ZERO(1'b1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .rd_addr1_i(ra[0]), .rd_addr2_i(ra[1]), .rd_addr3_i(ra[2]),
        .rd_use1_i(ru[0]), .rd_use2_i(ru[1]), .rd_use3_i(ru[2]),
        .rd_data1_o(rd[1][0]), .rd_data2_o(rd[1][1]), .rd_data3_o(rd[1][2]),
        .wr_en_i(we), .wr_addr_i(wa), .wr_data_i(wd),
        .iss_en_i(ie), .iss_addr_i(ia),
        .busy1_o(bz[1][0]), .busy2_o(bz[1][1]), .busy3_o(bz[1][2]),
        .stall_o(st[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    task automatic idle_inputs();
        we = 1'b0; wa = '0; wd = '0; ie = 1'b0; ia = '0;
        for (int p = 0; p < 3; p++) begin
            ra[p] = '0;
            ru[p] = 1'b0;
        end
    endtask

    // Expected values derived from the model and the current inputs.
    function automatic logic [31:0] exp_rd(input int m, input logic [4:0] a);
        if (m == 1 && a == 5'd0) return 32'd0;
        if (we && wa == a) return wd;
        return mreg[m][a];
    endfunction

    function automatic logic exp_busy(input int m, input logic [4:0] a);
        return mbusy[m][a] && !(we && wa == a);
    endfunction

    function automatic logic exp_stall(input int m);
        logic s = 1'b0;
        for (int p = 0; p < 3; p++) s |= ru[p] && exp_busy(m, ra[p]);
        return s;
    endfunction

    task automatic model_clear();
        for (int m = 0; m < 2; m++)
            for (int k = 0; k < 32; k++) begin
                mreg[m][k]  = '0;
                mbusy[m][k] = 1'b0;
            end
    endtask

    // Applies one clock edge of the current inputs to the model.
    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            logic s = exp_stall(m);
            if (we && !(m == 1 && wa == 5'd0)) mreg[m][wa] = wd;
            if (we) mbusy[m][wa] = 1'b0;
            if (ie && !s && !(m == 1 && ia == 5'd0)) mbusy[m][ia] = 1'b1;
        end
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        // Directed table: {we,wa,wd,ie,ia,a1,a2,a3,u1,u2,u3,e1,e2,e3,b1,b2,b3,stall}
        vecs[0]  = '{1, 7, 32'hDEADBEEF, 0, 0, 7, 8, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{0, 0, 0, 0, 0, 7, 8, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0};
        vecs[2]  = '{1, 3, 32'h11, 0, 0, 3, 7, 3, 0, 0, 0, 32'h11, 32'hDEADBEEF, 32'h11,
                     0, 0, 0, 0};
        vecs[3]  = '{1, 3, 32'h22, 0, 0, 3, 7, 3, 0, 0, 0, 32'h22, 32'hDEADBEEF, 32'h22,
                     0, 0, 0, 0};
        vecs[4]  = '{0, 0, 0, 0, 0, 3, 7, 3, 0, 0, 0, 32'h22, 32'hDEADBEEF, 32'h22, 0, 0, 0, 0};
        vecs[5]  = '{0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[6]  = '{0, 0, 0, 1, 6, 6, 5, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1};
        vecs[7]  = '{1, 5, 32'h55, 0, 0, 6, 5, 0, 0, 1, 0, 0, 32'h55, 0, 0, 0, 0, 0};
        vecs[8]  = '{0, 0, 0, 0, 0, 6, 5, 0, 0, 1, 0, 0, 32'h55, 0, 0, 0, 0, 0};
        vecs[9]  = '{0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[10] = '{1, 9, 32'h5, 1, 9, 0, 0, 9, 0, 0, 1, 0, 0, 32'h5, 0, 0, 0, 0};
        vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 0, 0, 32'h5, 0, 0, 1, 0};
        vecs[12] = '{0, 0, 0, 0, 0, 0, 0, 9, 0, 0, 1, 0, 0, 32'h5, 0, 0, 1, 1};
        vecs[13] = '{1, 9, 32'h6, 1, 10, 0, 0, 9, 0, 0, 1, 0, 0, 32'h6, 0, 0, 0, 0};
        vecs[14] = '{0, 0, 0, 0, 0, 9, 10, 0, 0, 1, 0, 32'h6, 0, 0, 0, 1, 0, 1};
        vecs[15] = '{1, 10, 32'h10, 0, 0, 9, 10, 0, 0, 1, 0, 32'h6, 32'h10, 0, 0, 0, 0, 0};
        vecs[16] = '{0, 0, 0, 0, 0, 9, 10, 3, 0, 1, 0, 32'h6, 32'h10, 32'h22, 0, 0, 0, 0};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("rst m%0d rd1", m), rd[m][0], 32'd0);
            chk($sformatf("rst m%0d busy1", m), {31'd0, bz[m][0]}, 32'd0);
            chk($sformatf("rst m%0d stall", m), {31'd0, st[m]}, 32'd0);
        end
        rst_n = 1'b1;

        // Directed vectors, checked on the falling edge before each update.
        for (int i = 0; i < 17; i++) begin
            we = vecs[i].we; wa = vecs[i].wa; wd = vecs[i].wd;
            ie = vecs[i].ie; ia = vecs[i].ia;
            ra[0] = vecs[i].a1; ra[1] = vecs[i].a2; ra[2] = vecs[i].a3;
            ru[0] = vecs[i].u1; ru[1] = vecs[i].u2; ru[2] = vecs[i].u3;
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                chk($sformatf("vec%0d m%0d rd1", i, m), rd[m][0], vecs[i].e1);
                chk($sformatf("vec%0d m%0d rd2", i, m), rd[m][1], vecs[i].e2);
                chk($sformatf("vec%0d m%0d rd3", i, m), rd[m][2], vecs[i].e3);
                chk($sformatf("vec%0d m%0d busy1", i, m), {31'd0, bz[m][0]}, {31'd0, vecs[i].b1});
                chk($sformatf("vec%0d m%0d busy2", i, m), {31'd0, bz[m][1]}, {31'd0, vecs[i].b2});
                chk($sformatf("vec%0d m%0d busy3", i, m), {31'd0, bz[m][2]}, {31'd0, vecs[i].b3});
                chk($sformatf("vec%0d m%0d stall", i, m), {31'd0, st[m]}, {31'd0, vecs[i].es});
            end
            @(posedge clk);
            #1;
        end

        // R0 handling: ordinary register in mode 0, hardwired zero in mode 1.
        idle_inputs();
        we = 1'b1; wa = 5'd0; wd = 32'hFFFF;
        #1;
        chk("r0 bypass m0", rd[0][0], 32'hFFFF);
        chk("r0 bypass m1", rd[1][0], 32'd0);
        @(posedge clk); #1;
        we = 1'b0; ie = 1'b1; ia = 5'd0;
        #1;
        chk("r0 read m0", rd[0][0], 32'hFFFF);
        chk("r0 read m1", rd[1][0], 32'd0);
        @(posedge clk); #1;
        ie = 1'b0; ru[0] = 1'b1;
        #1;
        chk("r0 busy m0", {31'd0, bz[0][0]}, 32'd1);
        chk("r0 stall m0", {31'd0, st[0]}, 32'd1);
        chk("r0 busy m1", {31'd0, bz[1][0]}, 32'd0);
        chk("r0 stall m1", {31'd0, st[1]}, 32'd0);

        // Asynchronous reset between edges; traffic during reset is lost.
        idle_inputs();
        we = 1'b1; wa = 5'd12; wd = 32'hA5; ie = 1'b1; ia = 5'd12;
        @(posedge clk); #1;
        we = 1'b0; ie = 1'b0; ra[0] = 5'd12; ru[0] = 1'b1;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("prerst m%0d rd1", m), rd[m][0], 32'hA5);
            chk($sformatf("prerst m%0d busy1", m), {31'd0, bz[m][0]}, 32'd1);
        end
        rst_n = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("inrst m%0d rd1", m), rd[m][0], 32'd0);
            chk($sformatf("inrst m%0d busy1", m), {31'd0, bz[m][0]}, 32'd0);
            chk($sformatf("inrst m%0d stall", m), {31'd0, st[m]}, 32'd0);
        end
        we = 1'b1; wa = 5'd13; wd = 32'h77; ie = 1'b1; ia = 5'd14; ra[1] = 5'd13;
        #1;
        chk("inrst bypass", rd[0][1], 32'h77);
        @(posedge clk); #1;
        we = 1'b0; ie = 1'b0;
        #1;
        chk("inrst write lost", rd[0][1], 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        ra[2] = 5'd14; ru[2] = 1'b1;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("postrst m%0d busy3", m), {31'd0, bz[m][2]}, 32'd0);
            chk($sformatf("postrst m%0d stall", m), {31'd0, st[m]}, 32'd0);
        end
        we = 1'b1; wa = 5'd12; wd = 32'h3C;
        @(posedge clk); #1;
        we = 1'b0;
        #1;
        for (int m = 0; m < 2; m++)
            chk($sformatf("postrst m%0d rd12", m), rd[m][0], 32'h3C);

        // Randomized traffic against the reference model.
        idle_inputs();
        rst_n = 1'b0;
        model_clear();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 600; c++) begin
            we = 1'($urandom_range(0, 1));
            wa = 5'($urandom_range(0, 7));
            wd = $urandom;
            ie = 1'($urandom_range(0, 1));
            ia = 5'($urandom_range(0, 7));
            for (int p = 0; p < 3; p++) begin
                ra[p] = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(8, 31))
                                                    : 5'($urandom_range(0, 7));
                ru[p] = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                for (int p = 0; p < 3; p++) begin
                    chk($sformatf("rnd%0d m%0d rd%0d", c, m, p + 1), rd[m][p], exp_rd(m, ra[p]));
                    chk($sformatf("rnd%0d m%0d busy%0d", c, m, p + 1), {31'd0, bz[m][p]},
                        {31'd0, exp_busy(m, ra[p])});
                end
                chk($sformatf("rnd%0d m%0d stall", c, m), {31'd0, st[m]},
                    {31'd0, exp_stall(m)});
            end
            @(posedge clk);
            model_step();
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
